// File: rtl/bvuge_bvmul_skolem_seq.sv
// rtl/bvuge_bvmul_skolem_seq.sv - sequential Skolem search for (a*x mod 2^W) >=/> b
module bvuge_bvmul_skolem_seq #(
    parameter int W         = 4,
    parameter int CMP_MODE  = 0,
    parameter int FAST_ZERO = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         found,
    output logic [W:0]   iters
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         live;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] cnt;
    logic [W-1:0] prod;
    logic         hit;
    logic         last;
    logic         fast;
    logic         accept;

    // W-bit result context keeps exactly the low W bits of the full 2W-bit product
    assign prod   = a_r * cnt;
    assign hit    = (CMP_MODE != 0) ? (prod > b_r) : (prod >= b_r);
    assign last   = &cnt;
    assign fast   = (FAST_ZERO != 0) && (CMP_MODE == 0) && (b == '0);
    assign accept = in_valid && in_ready;

    // live holds in_ready low while reset is asserted even though state is IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = fast ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (hit || last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = live;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
            x     <= '0;
            found <= 1'b0;
            iters <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= '0;
                        x     <= '0;
                        found <= fast;
                        iters <= fast ? {{W{1'b0}}, 1'b1} : '0;
                    end
                end
                SEARCH: begin
                    if (abort) begin
                        x     <= '0;
                        found <= 1'b0;
                        iters <= '0;
                    end else begin
                        iters <= iters + 1'b1;
                        if (hit) begin
                            x     <= cnt;
                            found <= 1'b1;
                        end else if (last) begin
                            x     <= '0;
                            found <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        x     <= '0;
                        found <= 1'b0;
                        iters <= '0;
                    end
                end
                default: begin
                    x     <= '0;
                    found <= 1'b0;
                    iters <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bvuge_bvmul_skolem_seq.sv
// tb/tb_bvuge_bvmul_skolem_seq.sv - scoreboard bench for bvuge_bvmul_skolem_seq
module tb_bvuge_bvmul_skolem_seq;

    localparam int W  = 4;
    localparam int ND = 3;

    typedef struct {
        int xe;
        int fe;
        int ie;
        int lat;
        int acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [W-1:0] a         [ND];
    logic [W-1:0] b         [ND];
    logic         abort     [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [W-1:0] x         [ND];
    logic         found     [ND];
    logic [W:0]   iters     [ND];

    exp_t sbq [ND][$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // dut 0: uge fast-zero, dut 1: ugt, dut 2: uge without fast-zero
    for (genvar g = 0; g < ND; g++) begin : g_dut
        bvuge_bvmul_skolem_seq #(
            .W(W),
            .CMP_MODE(g == 1 ? 1 : 0),
            .FAST_ZERO(g == 2 ? 0 : 1)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .a(a[g]),
            .b(b[g]),
            .abort(abort[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .x(x[g]),
            .found(found[g]),
            .iters(iters[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", name, d, act, req);
        end
    endtask

    function automatic void model(input int mode, input int av, input int bv,
                                  output int xe, output int fe, output int ie);
        xe = 0;
        fe = 0;
        ie = 16;
        for (int k = 0; k < 16; k++) begin
            int p;
            p = (av * k) % 16;
            if (fe == 0 && (mode != 0 ? p > bv : p >= bv)) begin
                xe = k;
                fe = 1;
                ie = k + 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst_n && out_valid[d] && out_ready[d]) begin
                if (sbq[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result dut%0d x=%0d found=%0d iters=%0d, required no result",
                             d, x[d], found[d], iters[d]);
                end else begin
                    mon_e = sbq[d].pop_front();
                    chk("x", d, int'(x[d]), mon_e.xe);
                    chk("found", d, int'(found[d]), mon_e.fe);
                    chk("iters", d, int'(iters[d]), mon_e.ie);
                    if (mon_e.lat >= 0) chk("latency", d, cyc - mon_e.acc, mon_e.lat);
                end
            end
        end
    end

    task automatic send(input int d, input int av, input int bv, input int xe, input int fe,
                        input int ie, input int lat, input bit push);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            chk("accept_timeout", d, 0, 1);
            return;
        end
        a[d] = av[W-1:0];
        b[d] = bv[W-1:0];
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        if (push) begin
            e.xe = xe; e.fe = fe; e.ie = ie; e.lat = lat; e.acc = cyc;
            sbq[d].push_back(e);
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sbq[d].size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq[d].size() > 0) begin
            chk("result_timeout", d, sbq[d].size(), 0);
            sbq[d].delete();
        end
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", d, int'(out_valid[d]), 1);
    endtask

    initial begin
        int xe, fe, ie;
        #100_000_000;
        $display("FAIL watchdog dut0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xe, fe, ie;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 1'b0; abort[d] = 1'b0; out_ready[d] = 1'b1;
            a[d] = '0; b[d] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 0, int'(in_ready[0]), 0);
        chk("rst_out_valid", 0, int'(out_valid[0]), 0);
        chk("rst_x", 0, int'(x[0]), 0);
        chk("rst_found", 0, int'(found[0]), 0);
        chk("rst_iters", 0, int'(iters[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 0, int'(in_ready[0]), 1);

        // directed vectors
        send(0, 3, 10, 4, 1, 5, 5, 1);   drain(0);
        send(0, 5, 14, 3, 1, 4, 4, 1);   drain(0);
        send(0, 2, 15, 0, 0, 16, -1, 1); drain(0);
        send(0, 7, 0, 0, 1, 1, -1, 1);   drain(0);
        send(2, 7, 0, 0, 1, 1, 1, 1);    drain(2);
        send(2, 3, 10, 4, 1, 5, 5, 1);   drain(2);
        send(1, 1, 15, 0, 0, 16, -1, 1); drain(1);
        send(1, 1, 14, 15, 1, 16, 16, 1); drain(1);
        send(1, 3, 0, 1, 1, 2, 2, 1);    drain(1);

        // backpressure in DONE
        out_ready[0] = 1'b0;
        send(0, 3, 10, 4, 1, 5, -1, 1);
        wait_valid(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 0, int'(out_valid[0]), 1);
            chk("hold_x", 0, int'(x[0]), 4);
            chk("hold_iters", 0, int'(iters[0]), 5);
            chk("hold_in_ready", 0, int'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        drain(0);

        // abort mid-SEARCH
        send(0, 0, 5, 0, 0, 0, -1, 0);
        repeat (2) @(negedge clk);
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 0, int'(in_ready[0]), 1);
        chk("abort_out_valid", 0, int'(out_valid[0]), 0);
        chk("abort_iters", 0, int'(iters[0]), 0);
        repeat (25) @(negedge clk);

        // abort in DONE takes priority over the result
        out_ready[0] = 1'b0;
        send(0, 3, 10, 0, 0, 0, -1, 0);
        wait_valid(0);
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("abort_done_valid", 0, int'(out_valid[0]), 0);
        chk("abort_done_x", 0, int'(x[0]), 0);
        chk("abort_done_found", 0, int'(found[0]), 0);

        // asynchronous reset mid-SEARCH
        send(0, 0, 5, 0, 0, 0, -1, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_iters", 0, int'(iters[0]), 0);
        chk("arst_out_valid", 0, int'(out_valid[0]), 0);
        chk("arst_in_ready", 0, int'(in_ready[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release_ready", 0, int'(in_ready[0]), 1);

        // exhaustive sweep against the golden model
        for (int m = 0; m < 2; m++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    model(m, av, bv, xe, fe, ie);
                    send(m, av, bv, xe, fe, ie, -1, 1);
                    drain(m);
                end
            end
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
